// File: rtl/grant_sequencer.sv
// -----------------------------------------------------------------------------
// grant_sequencer
//   Round-robin arbiter that shares one resource among 8 requesters. The
//   current owner keeps the grant while it goes on requesting. A hold limit
//   caps how many cycles in a row one owner can keep it. On release the grant
//   passes straight to the next winner, with no idle cycle in between.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per owner (0 = unlimited)
//   HOLD_W    hold counter width, 2**HOLD_W > MAX_HOLD
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   en           in   1 = new grants may be issued; does not affect the current owner
//   req[7:0]     in   request vector, bit i = requester i
//   grant[7:0]   out  registered one-hot grant, zero when there is no owner
//   grant_code   out  binary index of the grant bit, 0 when there is no owner
//   grant_valid  out  high while any grant bit is set
//   preempt      out  one-cycle pulse after the hold limit forces a release
// -----------------------------------------------------------------------------
module grant_sequencer #(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_code,
   output logic       grant_valid,
   output logic       preempt
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};

   logic [0:0]        state_reg, state_next;
   logic [2:0]        ptr_reg, ptr_next;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic [7:0]        grant_reg, grant_next;
   logic [2:0]        code_reg, code_next;
   logic              preempt_reg, preempt_next;

   // Rotate the request vector so that position 0 is the search start (ptr).
   // A plain lowest-index priority pick on the rotated vector then gives
   // the round-robin winner. The 3-bit sum wraps modulo 8 by itself.
   logic [7:0] rot_req;
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rot
         assign rot_req[gi] = req[ptr_reg + 3'(gi)];
      end
   endgenerate

   logic [2:0] win_off;
   logic [2:0] win_idx;
   logic       win_found;

   always_comb begin
      win_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rot_req[i]) win_off = 3'(i);
      end
   end

   assign win_found = |req;
   assign win_idx   = ptr_reg + win_off;

   // The owner's own request and the hold-limit condition. code_reg holds
   // the owner index while the state is BUSY.
   logic owner_req;
   logic limit_hit;

   assign owner_req = req[code_reg];
   assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIMIT);

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      hold_cnt_next = hold_cnt_reg;
      grant_next    = grant_reg;
      code_next     = code_reg;
      preempt_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (en && win_found) begin
               grant_next    = 8'd1 << win_idx;
               code_next     = win_idx;
               hold_cnt_next = HOLD_ONE;
               ptr_next      = win_idx + 3'd1;
               state_next    = BUSY;
            end
         end
         BUSY: begin
            if (owner_req && !limit_hit) begin
               if (hold_cnt_reg != HOLD_SAT) hold_cnt_next = hold_cnt_reg + HOLD_ONE;
            end else begin
               // In this branch owner_req can only be high when the
               // limit forced the release, so it marks a preemption.
               preempt_next = owner_req;
               if (en && win_found) begin
                  // ptr is already owner+1. A limited owner that is the
                  // only requester is found last and gets the grant again.
                  grant_next    = 8'd1 << win_idx;
                  code_next     = win_idx;
                  hold_cnt_next = HOLD_ONE;
                  ptr_next      = win_idx + 3'd1;
               end else begin
                  grant_next    = 8'd0;
                  code_next     = 3'd0;
                  hold_cnt_next = '0;
                  state_next    = IDLE;
               end
            end
         end
         default: begin
            state_next    = IDLE;
            grant_next    = 8'd0;
            code_next     = 3'd0;
            hold_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         ptr_reg      <= 3'd0;
         hold_cnt_reg <= '0;
         grant_reg    <= 8'd0;
         code_reg     <= 3'd0;
         preempt_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         hold_cnt_reg <= hold_cnt_next;
         grant_reg    <= grant_next;
         code_reg     <= code_next;
         preempt_reg  <= preempt_next;
      end
   end

   assign grant       = grant_reg;
   assign grant_code  = code_reg;
   assign grant_valid = |grant_reg;
   assign preempt     = preempt_reg;

endmodule

// File: tb/tb_grant_sequencer.sv
// -----------------------------------------------------------------------------
// tb_grant_sequencer
//   Self-checking bench for grant_sequencer. A behavioural model tracks the
//   owner as an integer index (-1 = none), a hold count and a search start.
//   Every clock the bench compares the DUT outputs with that model. Directed
//   scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_grant_sequencer;

   localparam int MAX_HOLD = 16;
   localparam int HOLD_W   = 5;
   localparam int CNT_MAX  = (1 << HOLD_W) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_code;
   logic       grant_valid;
   logic       preempt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model state
   int m_owner = -1;
   int m_cnt   = 0;
   int m_ptr   = 0;
   bit m_pre   = 1'b0;

   grant_sequencer #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .req         (req),
      .grant       (grant),
      .grant_code  (grant_code),
      .grant_valid (grant_valid),
      .preempt     (preempt)
   );

   always #5 clk = ~clk;

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
      end
   endtask

   // First requester found scanning p, p+1, ... modulo 8
   function automatic int pick(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++) begin
         if (r[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   task automatic model_update();
      int w;
      if (rst) begin
         m_owner = -1; m_cnt = 0; m_ptr = 0; m_pre = 1'b0;
      end else if (m_owner < 0) begin
         m_pre = 1'b0;
         if (en && req != 8'd0) begin
            w = pick(req, m_ptr);
            m_owner = w; m_cnt = 1; m_ptr = (w + 1) % 8;
         end
      end else begin
         bit still_req;
         bit at_limit;
         still_req = req[m_owner];
         at_limit  = (MAX_HOLD != 0) && (m_cnt >= MAX_HOLD);
         if (still_req && !at_limit) begin
            m_pre = 1'b0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         end else begin
            m_pre = still_req && at_limit;
            if (en && req != 8'd0) begin
               w = pick(req, m_ptr);
               m_owner = w; m_cnt = 1; m_ptr = (w + 1) % 8;
            end else begin
               m_owner = -1; m_cnt = 0;
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic [7:0] e_grant;
      logic [2:0] e_code;
      e_grant = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
      e_code  = (m_owner < 0) ? 3'd0 : 3'(m_owner);
      chk("grant",   32'(grant),       32'(e_grant));
      chk("code",    32'(grant_code),  32'(e_code));
      chk("valid",   32'(grant_valid), 32'(m_owner >= 0));
      chk("preempt", 32'(preempt),     32'(m_pre));
      chk("onehot",  32'($onehot0(grant)), 32'd1);
      $display("cyc %0d rst=%0b en=%0b req=%02h -> grant=%02h code=%0d valid=%0b preempt=%0b",
               cyc, rst, en, req, grant, grant_code, grant_valid, preempt);
   endtask

   // One clock: inputs are stable across the edge; outputs are sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      cyc++;
      model_update();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int pc;
      int drops;
      rst = 1'b1; en = 1'b1; req = 8'hFF;

      // 1: reset with all requesting, then the first grant goes to requester 0
      do_reset();
      chk("t1_rst_grant", 32'(grant), 32'h0);
      step();
      chk("t1_first_grant", 32'(grant), 32'h01);

      // 2: back-to-back rotation; the owner drops its request after one cycle
      for (int i = 1; i <= 9; i++) begin
         req = 8'hFF & ~(8'd1 << m_owner);
         step();
         chk("t2_rr_code", 32'(grant_code), 32'(i % 8));
      end

      // 3: two requesters sharing under the hold limit
      req = 8'h0C; do_reset();
      pc = 0;
      repeat (50) begin
         step();
         if (preempt) pc++;
      end
      chk("t3_preempts", 32'(pc), 32'd3);

      // 4: single requester is granted again at the limit, with no gap
      req = 8'h20; do_reset();
      step();
      pc = 0; drops = 0;
      repeat (40) begin
         step();
         if (preempt) pc++;
         if (!grant_valid) drops++;
      end
      chk("t4_preempts", 32'(pc), 32'd2);
      chk("t4_valid_drops", 32'(drops), 32'd0);

      // 5: en low does not disturb the current owner
      req = 8'h10; do_reset();
      step();
      chk("t5_own4", 32'(grant), 32'h10);
      en = 1'b0; req = 8'h90;
      repeat (5) step();
      chk("t5_keep4", 32'(grant), 32'h10);
      req = 8'h80;
      step();
      chk("t5_idle", 32'(grant), 32'h0);
      step();
      en = 1'b1;
      step();
      chk("t5_grant7", 32'(grant), 32'h80);
      chk("t5_code7", 32'(grant_code), 32'd7);

      // 6: reset in the middle of a grant restarts the pointer at 0
      req = 8'hFF;
      repeat (3) step();
      rst = 1'b1;
      step();
      chk("t6_rst_clear", 32'(grant), 32'h0);
      rst = 1'b0; req = 8'h81;
      step();
      chk("t6_ptr0", 32'(grant), 32'h01);

      // randomized traffic; requests change now and then so limits get hit
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) req = 8'($urandom);
            else req = 8'($urandom & $urandom & $urandom);
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
